// File: rtl/exp_subt_arbiter_pkg.sv
// exp_subt_arbiter_pkg
// Shared definitions for the two-requester subtract arbiter: FSM state
// encoding, requester-id type and the subtrahend width.
package exp_subt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Identifies requester 0 or requester 1.
    typedef logic req_id_t;

    // Width of the B (subtrahend) operand.
    localparam int unsigned B_W = 5;

endpackage

// File: rtl/exp_subt_arbiter_s_subt.sv
// s_subt
// Combinational subtractor: y_o = a_i - {0, b_i}, modulo 2^P.
// The subtrahend is zero-extended to P bits.
// Ports:
//   a_i  [P-1:0]    minuend
//   b_i  [B_W-1:0]  subtrahend
//   y_o  [P-1:0]    difference
module s_subt
    import exp_subt_arbiter_pkg::*;
#(
    parameter int P = 8
) (
    input  logic [P-1:0]   a_i,
    input  logic [B_W-1:0] b_i,
    output logic [P-1:0]   y_o
);

    assign y_o = a_i - P'(b_i);

endmodule

// File: rtl/exp_subt_arbiter.sv
// exp_subt_arbiter
// Two-requester round-robin arbiter in front of a shared subtractor.
// IDLE samples requests and latches the winner's operands, CALC pulses the
// grant and registers the result, RESP pulses done and moves the
// round-robin pointer to the requester that lost.
// Build option: define S_SUBT_UFLOW_SAT_EN to saturate Y to 0 when A < B;
// otherwise Y carries the modulo-2^P difference. UFLOW is reported either way.
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   req0_i / req1_i   request lines
//   a0_i / a1_i       [P-1:0] minuends
//   b0_i / b1_i       [B_W-1:0] subtrahends
//   gnt0_o / gnt1_o   one-cycle pulse when operands are captured (CALC)
//   done0_o / done1_o one-cycle pulse when the result is on y_o (RESP)
//   y_o               [P-1:0] registered result
//   uflow_o           A < B for the result on y_o
//   busy_o            FSM not in IDLE
module exp_subt_arbiter
    import exp_subt_arbiter_pkg::*;
#(
    parameter int P = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           req0_i,
    input  logic           req1_i,
    input  logic [P-1:0]   a0_i,
    input  logic [P-1:0]   a1_i,
    input  logic [B_W-1:0] b0_i,
    input  logic [B_W-1:0] b1_i,
    output logic           gnt0_o,
    output logic           gnt1_o,
    output logic           done0_o,
    output logic           done1_o,
    output logic [P-1:0]   y_o,
    output logic           uflow_o,
    output logic           busy_o
);

    state_e         state_q, state_d;
    req_id_t        rr_q, rr_d;
    req_id_t        op_id_q, op_id_d;
    logic [P-1:0]   op_a_q, op_a_d;
    logic [B_W-1:0] op_b_q, op_b_d;
    logic [P-1:0]   y_q, y_d;
    logic           uflow_q, uflow_d;

    logic [P-1:0]   diff;
    logic           lt;
    req_id_t        winner;

    // Shared subtractor, always driven from the operand registers so input
    // changes after the sampling edge cannot reach the result.
    s_subt #(.P(P)) u_s_subt (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .y_o (diff)
    );

    assign lt = (op_a_q < P'(op_b_q));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        rr_d    = rr_q;
        op_id_d = op_id_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        y_d     = y_q;
        uflow_d = uflow_q;
        winner  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    // Contention goes to the pointer; otherwise the sole requester.
                    winner  = (req0_i && req1_i) ? rr_q : req1_i;
                    op_id_d = winner;
                    op_a_d  = winner ? a1_i : a0_i;
                    op_b_d  = winner ? b1_i : b0_i;
                    state_d = CALC;
                end
            end
            CALC: begin
                uflow_d = lt;
`ifdef S_SUBT_UFLOW_SAT_EN
                y_d     = lt ? '0 : diff;
`else
                y_d     = diff;
`endif
                state_d = RESP;
            end
            RESP: begin
                rr_d    = ~op_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand registers are reset together with the control state;
    // they are a handful of flops, not a memory array, so the reset is cheap
    // and keeps the subtractor inputs defined out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            op_id_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            y_q     <= '0;
            uflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            rr_q    <= rr_d;
            op_id_q <= op_id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            y_q     <= y_d;
            uflow_q <= uflow_d;
        end
    end

    // Pulses decode straight from state, so reset clears them immediately.
    assign gnt0_o  = (state_q == CALC) && (op_id_q == 1'b0);
    assign gnt1_o  = (state_q == CALC) && (op_id_q == 1'b1);
    assign done0_o = (state_q == RESP) && (op_id_q == 1'b0);
    assign done1_o = (state_q == RESP) && (op_id_q == 1'b1);
    assign busy_o  = (state_q != IDLE);
    assign y_o     = y_q;
    assign uflow_o = uflow_q;

endmodule

// File: tb/tb_exp_subt_arbiter.sv
// tb_exp_subt_arbiter
// Self-checking bench: the driver pushes the expected result of every
// operation into a scoreboard queue; a monitor pops and compares on DONE.
module tb_exp_subt_arbiter;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, a1 = '0;
    logic [4:0] b0 = '0, b1 = '0;
    logic       gnt0, gnt1, done0, done1, uflow, busy;
    logic [7:0] y;

    always #5 clk = ~clk;

    exp_subt_arbiter #(.P(P)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req0_i  (req0),
        .req1_i  (req1),
        .a0_i    (a0),
        .a1_i    (a1),
        .b0_i    (b0),
        .b1_i    (b1),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1),
        .done0_o (done0),
        .done1_o (done1),
        .y_o     (y),
        .uflow_o (uflow),
        .busy_o  (busy)
    );

    typedef struct {
        bit         id;
        logic [7:0] y;
        bit         uf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   rr_m = 1'b0;   // model of the round-robin pointer

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result from plain arithmetic.
    function automatic exp_t ref_model(input bit id, input int a, input int b);
        exp_t e;
        e.id = id;
        e.uf = (a < b);
        e.y  = 8'((a - b) & 255);
`ifdef S_SUBT_UFLOW_SAT_EN
        if (e.uf) e.y = 8'h00;
`endif
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever a DONE is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) check("one_gnt", {31'd0, gnt0 & gnt1}, 0);
            if (done0 || done1) begin
                check("one_done", {31'd0, done0 & done1}, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("done_id", {31'd0, done1}, {31'd0, mon_e.id});
                    check("y", {24'd0, y}, {24'd0, mon_e.y});
                    check("uflow", {31'd0, uflow}, {31'd0, mon_e.uf});
                end
            end
        end
    end

    // Issue one request pattern and follow it to completion. A requester
    // drops REQ and scrambles its operands when granted; a losing requester
    // keeps REQ high and is served next.
    task automatic drive_ops(input bit r0, input bit r1,
                             input logic [7:0] ia0, input logic [4:0] ib0,
                             input logic [7:0] ia1, input logic [4:0] ib1);
        bit order[2];
        int n;
        int cnt;
        bit w;
        @(negedge clk);
        req0 = r0; req1 = r1;
        a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
        if (r0 && r1) begin
            order[0] = rr_m; order[1] = ~rr_m; n = 2;
        end else begin
            order[0] = r1; order[1] = 1'b0; n = 1;
        end
        for (int k = 0; k < n; k++) begin
            w = order[k];
            sb_q.push_back(w ? ref_model(1'b1, int'(ia1), int'(ib1))
                             : ref_model(1'b0, int'(ia0), int'(ib0)));
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!(w ? gnt1 : gnt0) && cnt < 8);
            check(k == 0 ? "gnt_latency" : "gnt_second_latency", cnt, k == 0 ? 1 : 2);
            check("busy_in_calc", {31'd0, busy}, 1);
            if (w) begin
                req1 = 1'b0; a1 = 8'($urandom); b1 = 5'($urandom);
            end else begin
                req0 = 1'b0; a0 = 8'($urandom); b0 = 5'($urandom);
            end
            @(negedge clk);
            check("done_latency", {31'd0, w ? done1 : done0}, 1);
            rr_m = ~w;
        end
    endtask

    initial begin
        int r;
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_y", {24'd0, y}, 0);
        check("rst_uflow", {31'd0, uflow}, 0);
        check("rst_gnt", {30'd0, gnt1, gnt0}, 0);
        check("rst_done", {30'd0, done1, done0}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both requesting from reset: 0 first, then 1
        drive_ops(1, 1, 8'h10, 5'h01, 8'h20, 5'h02);
        // Equal operands
        drive_ops(1, 0, 8'h04, 5'h04, 8'h00, 5'h00);
        // Requester 1 alone
        drive_ops(0, 1, 8'h00, 5'h00, 8'h0B, 5'h02);
        // Underflow
        drive_ops(1, 0, 8'h03, 5'h05, 8'h00, 5'h00);
        // Boundaries
        drive_ops(0, 1, 8'h00, 5'h00, 8'hFF, 5'h1F);
        drive_ops(1, 0, 8'h00, 5'h1F, 8'h00, 5'h00);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(1, 3));
            drive_ops(r[0], r[1], 8'($urandom), 5'($urandom), 8'($urandom), 5'($urandom));
        end

        // Abort in CALC: leave the pointer at 1 first so the post-reset
        // winner shows the pointer really went back to 0.
        drive_ops(1, 0, 8'h33, 5'h03, 8'h00, 5'h00);
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h55; b0 = 5'h01;
        @(negedge clk);
        check("abort_gnt0", {31'd0, gnt0}, 1);
        rst_n = 1'b0;
        req0 = 1'b0;
        rr_m = 1'b0;
        #1;
        check("abort_y", {24'd0, y}, 0);
        check("abort_uflow", {31'd0, uflow}, 0);
        check("abort_gnt", {30'd0, gnt1, gnt0}, 0);
        check("abort_done", {30'd0, done1, done0}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        check("abort_no_done", {30'd0, done1, done0}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        drive_ops(1, 1, 8'h40, 5'h10, 8'h41, 5'h11);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exp_subt_arbiter.md
EXP_SUBT_ARBITER -- requirements
Module: exp_subt_arbiter

Interface
REQ-001: Parameter P, default 8, SHALL set the width of the A operand and the result Y.
REQ-002: CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-004: REQ0, REQ1  input  1 each  SHALL be the request line from requester 0 and requester 1.
REQ-005: A0, A1  input  P each  SHALL be the minuend from each requester.
REQ-006: B0, B1  input  5 each  SHALL be the subtrahend from each requester.
REQ-007: GNT0, GNT1  output  1 each  SHALL pulse for one cycle when that requester's operands are captured.
REQ-008: DONE0, DONE1  output  1 each  SHALL pulse for one cycle when that requester's result is valid on Y.
REQ-009: Y  output  P  SHALL carry the registered result A - B.
REQ-010: UFLOW  output  1  SHALL flag A < B, zero-extended, for the result on Y.
REQ-011: BUSY  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012: The FSM SHALL have three states, IDLE -> CALC -> RESP -> IDLE.
REQ-013: In IDLE, on any clock edge where at least one REQ is high, the block SHALL select a winner, latch its A, B and id into operand registers, and move to CALC.
REQ-014: The winner SHALL be the sole requester if only one REQ is high; if both are high, it SHALL be the requester indicated by the round-robin pointer.
REQ-015: In CALC, GNTid SHALL be high for exactly this cycle; at the end of this cycle, Y and UFLOW SHALL load from the shared S_SUBT output driven by the operand registers.
REQ-016: In RESP, DONEid SHALL be high for exactly this cycle.
REQ-017: At the end of RESP, the round-robin pointer SHALL point to the requester that did not win, and the FSM SHALL return to IDLE.
REQ-018: Latency SHALL be 2 cycles from the sampling edge to DONE, and throughput SHALL be at most one operation per 3 cycles.
REQ-019: Operands SHALL only need to be stable at the sampling edge; input changes after that edge SHALL NOT affect the result.
REQ-020: A requester SHALL drop REQ on seeing GNT; a REQ still high when the FSM re-enters IDLE SHALL be treated as a new request.
REQ-021: When REQ is asserted outside IDLE, it SHALL be ignored until the FSM returns to IDLE.
REQ-022: The subtraction SHALL be A minus {0, B}, with B zero-extended to P bits and computed modulo 2^P.
REQ-023: UFLOW SHALL equal 1 exactly when A < B.
REQ-024: Y and UFLOW SHALL hold their values until the next CALC cycle.
REQ-025: At most one GNT and at most one DONE SHALL be high in any cycle.

Reset
REQ-026: While RST is low, the block SHALL be held in reset asynchronously: state=IDLE, round-robin pointer=0, Y=0, UFLOW=0, GNT0/1=0, DONE0/1=0, BUSY=0, operand registers=0.
REQ-027: A reset asserted during CALC or RESP SHALL abort the operation, and no DONE SHALL be issued for it.
REQ-028: Reset release SHALL take effect at the first rising CLK edge after RST goes high.

Configuration
REQ-029: The macro S_SUBT_UFLOW_SAT_EN SHALL select underflow handling.
REQ-030: With S_SUBT_UFLOW_SAT_EN defined, when A < B, Y SHALL load 0 and UFLOW SHALL be 1.
REQ-031: Without S_SUBT_UFLOW_SAT_EN, Y SHALL load the modulo-2^P difference and UFLOW SHALL still be reported.

Structure
REQ-032: A shared package SHALL hold the state encoding (IDLE=2'd0, CALC=2'd1, RESP=2'd2), the requester-id type (1 bit) and the B width constant (5).
REQ-033: The block SHALL contain exactly one sub-module, an instance of the existing S_SUBT subtractor.
REQ-034: The arbiter SHALL contain no arithmetic of its own beyond the underflow compare and the saturation mux.

Verification
REQ-035: The bench SHALL drive REQ0 with A0=8'h04, B0=5'h04 and check GNT0 in the next cycle, DONE0 one cycle later, Y=8'h00 and UFLOW=0.
REQ-036: The bench SHALL drive REQ1 with A1=8'h0B, B1=5'h02 and check Y=8'h09, UFLOW=0 and DONE1 only.
REQ-037: The bench SHALL drive REQ0 and REQ1 together from reset (A0=8'h10/B0=5'h01, A1=8'h20/B1=5'h02), hold both, and check service order 0 then 1 with Y=8'h0F then 8'h1E, and never both GNTs in one cycle.
REQ-038: The bench SHALL drive A0=8'h03, B0=5'h05 and check UFLOW=1 with Y=8'hFE when S_SUBT_UFLOW_SAT_EN is undefined, or Y=8'h00 when it is defined.
REQ-039: The bench SHALL pull RST low in the CALC cycle and check that all outputs go to 0 immediately, no DONE is issued, and a request after release is served by requester 0 first.
REQ-040: The bench SHALL change A0 in the cycle after the sampling edge and check that Y reflects the originally sampled value.
